// File: rtl/mult_div_unit.sv
`default_nettype none
// ============================================================================
//  Module      : mult_div_unit
//  Description : Multi-cycle MIPS-style HI/LO multiply/divide unit. Operands
//                are latched at start, busy is held for a fixed number of
//                cycles, then HI/LO are written in one edge. mthi/mtlo write
//                HI/LO directly while idle.
//  Revision    : 1.0 - initial release
// ============================================================================
module mult_div_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int c_MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int c_CNT_BITS   = $clog2(c_MAX_CYCLES + 1);
    localparam int c_CNT_W      = (c_CNT_BITS > 4) ? c_CNT_BITS : 4;

    localparam logic [2:0] c_OP_MTHI = 3'd4;
    localparam logic [2:0] c_OP_MTLO = 3'd5;

    localparam logic [c_CNT_W-1:0] c_MULT_LOAD = c_CNT_W'(MULT_CYCLES);
    localparam logic [c_CNT_W-1:0] c_DIV_LOAD  = c_CNT_W'(DIV_CYCLES);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [c_CNT_W-1:0]  r_cnt;
    logic [c_CNT_W-1:0]  w_cnt_nxt;
    logic                w_accept;
    logic                w_done;
    logic                w_load_hi;
    logic                w_load_lo;

    // Operands captured at accept; r_op[1] selects divide, r_op[0] unsigned.
    logic [31:0]         r_a;
    logic [31:0]         r_b;
    logic [1:0]          r_op;
    logic [31:0]         r_hi;
    logic [31:0]         r_lo;

    logic                w_is_signed;
    logic [63:0]         w_prod;
    logic                w_a_neg;
    logic                w_b_neg;
    logic [31:0]         w_num_mag;
    logic [31:0]         w_den_mag;
    logic [31:0]         w_q_mag;
    logic [31:0]         w_r_mag;
    logic [31:0]         w_quot;
    logic [31:0]         w_rem;

    // State and counter register; reset forces IDLE with a cleared counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state, counter and write-enable decode.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_accept    = 1'b0;
        w_done      = 1'b0;
        w_load_hi   = 1'b0;
        w_load_lo   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    if (op[2] == 1'b0) begin
                        w_accept    = 1'b1;
                        w_state_nxt = S_RUN;
                        w_cnt_nxt   = op[1] ? c_DIV_LOAD : c_MULT_LOAD;
                    end else if (op == c_OP_MTHI) begin
                        w_load_hi = 1'b1;
                    end else if (op == c_OP_MTLO) begin
                        w_load_lo = 1'b1;
                    end
                end
            end
            S_RUN: begin
                // The edge that sees a count of one closes the Nth busy cycle.
                if (r_cnt <= c_CNT_ONE) begin
                    w_done      = 1'b1;
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt - c_CNT_ONE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Result datapath: low 64 bits of a 64x64 product on extended operands.
    always_comb begin
        w_is_signed = ~r_op[0];
        if (w_is_signed) begin
            w_prod = {{32{r_a[31]}}, r_a} * {{32{r_b[31]}}, r_b};
        end else begin
            w_prod = {32'd0, r_a} * {32'd0, r_b};
        end
    end

    // Divide on magnitudes, then restore signs: quotient truncates toward
    // zero and the remainder follows the dividend. A zero divisor is
    // replaced by one only to keep the divider defined; its result is unused.
    always_comb begin
        w_a_neg   = w_is_signed & r_a[31];
        w_b_neg   = w_is_signed & r_b[31];
        w_num_mag = w_a_neg ? (32'd0 - r_a) : r_a;
        if (r_b == 32'd0) begin
            w_den_mag = 32'd1;
        end else begin
            w_den_mag = w_b_neg ? (32'd0 - r_b) : r_b;
        end
        w_q_mag = w_num_mag / w_den_mag;
        w_r_mag = w_num_mag % w_den_mag;
        w_quot  = (w_a_neg ^ w_b_neg) ? (32'd0 - w_q_mag) : w_q_mag;
        w_rem   = w_a_neg ? (32'd0 - w_r_mag) : w_r_mag;
    end

    // Operand latch and HI/LO register updates.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_a  <= '0;
            r_b  <= '0;
            r_op <= '0;
            r_hi <= '0;
            r_lo <= '0;
        end else begin
            if (w_accept) begin
                r_a  <= a;
                r_b  <= b;
                r_op <= op[1:0];
            end
            if (w_load_hi) begin
                r_hi <= a;
            end
            if (w_load_lo) begin
                r_lo <= a;
            end
            if (w_done) begin
                if (r_op[1] == 1'b0) begin
                    r_hi <= w_prod[63:32];
                    r_lo <= w_prod[31:0];
                end else if (r_b != 32'd0) begin
                    r_hi <= w_rem;
                    r_lo <= w_quot;
                end
            end
        end
    end

    assign busy = (r_state == S_RUN);
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_mult_div_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mult_div_unit
//  Description : Self-checking bench for mult_div_unit: directed cases plus
//                random operations compared against an arithmetic model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mult_div_unit;

    localparam int c_MULT_N = 5;
    localparam int c_DIV_N  = 10;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int          total;
    int          bad;
    logic [31:0] m_hi;
    logic [31:0] m_lo;

    mult_div_unit #(
        .MULT_CYCLES (c_MULT_N),
        .DIV_CYCLES  (c_DIV_N)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .hi    (hi),
        .lo    (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Architectural effect of one accepted operation on HI/LO.
    task automatic ref_model(input logic [2:0] mop, input logic [31:0] ma, input logic [31:0] mb);
        longint          sa;
        longint          sb;
        longint          q;
        longint          r;
        longint unsigned ua;
        longint unsigned ub;
        longint unsigned p;
        sa = longint'($signed(ma));
        sb = longint'($signed(mb));
        ua = {32'd0, ma};
        ub = {32'd0, mb};
        case (mop)
            3'd0: begin
                q = sa * sb;
                m_hi = q[63:32];
                m_lo = q[31:0];
            end
            3'd1: begin
                p = ua * ub;
                m_hi = p[63:32];
                m_lo = p[31:0];
            end
            3'd2: begin
                if (mb != 0) begin
                    q = sa / sb;
                    r = sa % sb;
                    m_lo = q[31:0];
                    m_hi = r[31:0];
                end
            end
            3'd3: begin
                if (mb != 0) begin
                    p = ua / ub;
                    m_lo = p[31:0];
                    p = ua % ub;
                    m_hi = p[31:0];
                end
            end
            3'd4: m_hi = ma;
            3'd5: m_lo = ma;
            default: ;
        endcase
    endtask

    // Issue a mult/div at the current negedge and follow it to completion.
    // mode 1 scrambles all inputs during RUN; mode 2 tries an mtlo mid-RUN.
    task automatic run_op(input string tag, input logic [2:0] t_op, input logic [31:0] t_a,
                          input logic [31:0] t_b, input int mode);
        int cnt;
        int exp_n;
        start = 1'b1;
        op    = t_op;
        a     = t_a;
        b     = t_b;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        exp_n = t_op[1] ? c_DIV_N : c_MULT_N;
        ref_model(t_op, t_a, t_b);
        cnt = 0;
        while (busy === 1'b1 && cnt < 200) begin
            cnt++;
            if (mode == 1) begin
                a     = $urandom;
                b     = $urandom;
                op    = 3'($urandom_range(0, 7));
                start = 1'($urandom_range(0, 1));
            end else if (mode == 2 && cnt == 2) begin
                start = 1'b1;
                op    = 3'd5;
                a     = 32'h1;
            end else if (mode == 2 && cnt == 3) begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        check({tag, "_busy_cycles"}, 32'(cnt), 32'(exp_n));
        check({tag, "_hi"}, hi, m_hi);
        check({tag, "_lo"}, lo, m_lo);
    endtask

    // Issue a single-cycle op (mthi/mtlo/no-op) while idle.
    task automatic simple_op(input string tag, input logic [2:0] t_op, input logic [31:0] t_a);
        start = 1'b1;
        op    = t_op;
        a     = t_a;
        b     = $urandom;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        ref_model(t_op, t_a, 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_hi"}, hi, m_hi);
        check({tag, "_lo"}, lo, m_lo);
    endtask

    initial begin
        logic [2:0]  r_op_v;
        logic [31:0] r_a_v;
        logic [31:0] r_b_v;
        total = 0;
        bad   = 0;
        m_hi  = 32'd0;
        m_lo  = 32'd0;
        reset = 1'b1;
        start = 1'b1;
        op    = 3'd4;
        a     = 32'hDEADBEEF;
        b     = 32'd0;

        // Reset state, including start ignored while reset is high.
        #3;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        @(posedge clk);
        @(negedge clk);
        check("rst_start_ignored_hi", hi, 32'd0);
        start = 1'b0;
        reset = 1'b0;

        // First op accepted at the first edge after release.
        simple_op("mthi_first", 3'd4, 32'h12345678);
        simple_op("mtlo_init", 3'd5, 32'h0BADF00D);

        run_op("divu_by0", 3'd3, 32'h00001234, 32'd0, 0);
        check("divu_by0_hi_const", hi, 32'h12345678);
        check("divu_by0_lo_const", lo, 32'h0BADF00D);

        run_op("mult_m3x5", 3'd0, 32'hFFFFFFFD, 32'd5, 0);
        check("mult_m3x5_hi_const", hi, 32'hFFFFFFFF);
        check("mult_m3x5_lo_const", lo, 32'hFFFFFFF1);

        run_op("multu_max_x2", 3'd1, 32'hFFFFFFFF, 32'd2, 0);
        check("multu_hi_const", hi, 32'h00000001);
        check("multu_lo_const", lo, 32'hFFFFFFFE);

        run_op("div_m7_2", 3'd2, 32'hFFFFFFF9, 32'd2, 0);
        check("div_m7_2_lo_const", lo, 32'hFFFFFFFD);
        check("div_m7_2_hi_const", hi, 32'hFFFFFFFF);

        run_op("div_ovf", 3'd2, 32'h80000000, 32'hFFFFFFFF, 0);
        check("div_ovf_lo_const", lo, 32'h80000000);
        check("div_ovf_hi_const", hi, 32'h00000000);

        simple_op("mthi_aaaa", 3'd4, 32'hAAAA5555);
        check("mthi_aaaa_const", hi, 32'hAAAA5555);

        run_op("mult_mtlo_inj", 3'd0, 32'd1000, 32'd3, 2);

        run_op("mult_7x6_tog", 3'd0, 32'd7, 32'd6, 1);
        check("mult_7x6_lo_const", lo, 32'h0000002A);
        check("mult_7x6_hi_const", hi, 32'h00000000);
        run_op("mult_b2b", 3'd0, 32'hFFFF0001, 32'h00012345, 0);

        simple_op("nop6", 3'd6, 32'h55555555);
        simple_op("nop7", 3'd7, 32'h66666666);

        // Asynchronous reset during the third cycle of a div.
        start = 1'b1;
        op    = 3'd2;
        a     = 32'd1000;
        b     = 32'd7;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        m_hi = 32'd0;
        m_lo = 32'd0;
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_hi", hi, 32'd0);
        check("rst_mid_lo", lo, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (15) @(negedge clk);
        check("rst_after_busy", 32'(busy), 32'd0);
        check("rst_after_hi", hi, 32'd0);
        check("rst_after_lo", lo, 32'd0);

        // Random operations against the model.
        for (int i = 0; i < 40; i++) begin
            r_op_v = 3'($urandom_range(0, 7));
            r_a_v  = $urandom;
            r_b_v  = ($urandom_range(0, 7) == 0) ? 32'd0 :
                     ($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 300)) : $urandom;
            if (r_op_v[2] == 1'b0) begin
                run_op("rnd_md", r_op_v, r_a_v, r_b_v, int'($urandom_range(0, 1)));
            end else begin
                simple_op("rnd_simple", r_op_v, r_a_v);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
